// File: rtl/w0rm_periph_pkg.sv
// w0rm_periph_pkg: shared FSM encoding, master indices and timeout counter width
package w0rm_periph_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  localparam int CNT_W = 8;
endpackage

// File: rtl/w0rm_rr_pick2.sv
// w0rm_rr_pick2: two-requester round-robin grant, favouring the one not granted last
module w0rm_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       any
);
  always_comb begin
    any   = |req;
    grant = (req == 2'b11) ? ~last : req[1];
  end
endmodule

// File: rtl/w0rm_peripheral_bus_arbiter.sv
// w0rm_peripheral_bus_arbiter: two-master single-outstanding arbiter onto a shared peripheral bus
module w0rm_peripheral_bus_arbiter
  import w0rm_periph_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  mem_clk,
  input  logic                  cpu_reset,
  input  logic                  m0_valid_i,
  input  logic                  m0_read_i,
  input  logic                  m0_write_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic                  m0_valid_o,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_err_o,
  input  logic                  m1_valid_i,
  input  logic                  m1_read_i,
  input  logic                  m1_write_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic                  m1_valid_o,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_err_o,
  output logic                  mem_valid_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);
  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT - 1);
  state_e                  state_q, state_d;
  logic                    gnt_q, gnt_d, last_q, last_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    mv_q, mv_d, mrd_q, mrd_d, mwr_q, mwr_d;
  logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0]   mdata_q, mdata_d;
  logic                    m0v_q, m0v_d, m0e_q, m0e_d, m1v_q, m1v_d, m1e_q, m1e_d;
  logic [DATA_WIDTH-1:0]   m0d_q, m0d_d, m1d_q, m1d_d;
  logic [1:0]              req;
  logic                    pick, any;
  // A master's request during its own completion cycle is the one just served
  assign req = {m1_valid_i & ~m1v_q, m0_valid_i & ~m0v_q};
  w0rm_rr_pick2 u_pick (
    .req   (req),
    .last  (last_q),
    .grant (pick),
    .any   (any)
  );
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    mv_d    = 1'b0;
    mrd_d   = mrd_q;
    mwr_d   = mwr_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    m0v_d   = 1'b0;
    m0d_d   = m0d_q;
    m0e_d   = m0e_q;
    m1v_d   = 1'b0;
    m1d_d   = m1d_q;
    m1e_d   = m1e_q;
    case (state_q)
      IDLE: if (any) begin
        state_d = ISSUE;
        gnt_d   = pick;
        mv_d    = 1'b1;
        mrd_d   = (pick == M1) ? m1_read_i  : m0_read_i;
        mwr_d   = (pick == M1) ? m1_write_i : m0_write_i;
        maddr_d = (pick == M1) ? m1_addr_i  : m0_addr_i;
        mdata_d = (pick == M1) ? m1_data_i  : m0_data_i;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (mem_valid_i || cnt_q == TMAX) begin
        state_d = IDLE;
        last_d  = gnt_q;
        if (gnt_q == M1) begin
          m1v_d = 1'b1;
          m1d_d = mem_valid_i ? mem_data_i : '0;
          m1e_d = ~mem_valid_i;
        end else begin
          m0v_d = 1'b1;
          m0d_d = mem_valid_i ? mem_data_i : '0;
          m0e_d = ~mem_valid_i;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge mem_clk) begin
    if (cpu_reset) begin
      state_q <= IDLE;
      gnt_q   <= M0;
      last_q  <= M1;
      cnt_q   <= '0;
      mv_q    <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
      m0v_q   <= 1'b0;
      m0d_q   <= '0;
      m0e_q   <= 1'b0;
      m1v_q   <= 1'b0;
      m1d_q   <= '0;
      m1e_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      mv_q    <= mv_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      m0v_q   <= m0v_d;
      m0d_q   <= m0d_d;
      m0e_q   <= m0e_d;
      m1v_q   <= m1v_d;
      m1d_q   <= m1d_d;
      m1e_q   <= m1e_d;
    end
  end
  assign mem_valid_o = mv_q;
  assign mem_read_o  = mrd_q;
  assign mem_write_o = mwr_q;
  assign mem_addr_o  = maddr_q;
  assign mem_data_o  = mdata_q;
  assign m0_valid_o  = m0v_q;
  assign m0_data_o   = m0d_q;
  assign m0_err_o    = m0e_q;
  assign m1_valid_o  = m1v_q;
  assign m1_data_o   = m1d_q;
  assign m1_err_o    = m1e_q;
endmodule

// File: tb/tb_w0rm_peripheral_bus_arbiter.sv
// tb_w0rm_peripheral_bus_arbiter: directed scoreboard bench with a delay-programmable peripheral model
module tb_w0rm_peripheral_bus_arbiter;
  localparam int TO = 16;
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          delay;
    logic [31:0] rdata;
  } job_t;
  typedef struct {
    logic [31:0] data;
    logic        err;
  } cmp_t;
  logic mem_clk = 1'b0, cpu_reset = 1'b1;
  logic m0_valid_i = 0, m0_read_i = 0, m0_write_i = 0;
  logic [31:0] m0_addr_i = 0, m0_data_i = 0;
  logic m1_valid_i = 0, m1_read_i = 0, m1_write_i = 0;
  logic [31:0] m1_addr_i = 0, m1_data_i = 0;
  logic m0_valid_o, m0_err_o, m1_valid_o, m1_err_o;
  logic [31:0] m0_data_o, m1_data_o;
  logic mem_valid_o, mem_read_o, mem_write_o;
  logic [31:0] mem_addr_o, mem_data_o;
  logic mem_valid_i = 1'b0;
  logic [31:0] mem_data_i = 32'h0;
  job_t jobs0[$], jobs1[$], issq[$];
  cmp_t exp0[$], exp1[$];
  job_t je;
  cmp_t ce;
  int checks = 0, errors = 0, comp0 = 0, comp1 = 0;
  int nxt_delay = 0, pend = 0;
  logic [31:0] nxt_data = 0;
  w0rm_peripheral_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .mem_clk(mem_clk), .cpu_reset(cpu_reset),
    .m0_valid_i(m0_valid_i), .m0_read_i(m0_read_i), .m0_write_i(m0_write_i),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
    .m0_valid_o(m0_valid_o), .m0_data_o(m0_data_o), .m0_err_o(m0_err_o),
    .m1_valid_i(m1_valid_i), .m1_read_i(m1_read_i), .m1_write_i(m1_write_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
    .m1_valid_o(m1_valid_o), .m1_data_o(m1_data_o), .m1_err_o(m1_err_o),
    .mem_valid_o(mem_valid_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i)
  );
  always #5 mem_clk = ~mem_clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Queue the predicted bus issue and completion, then present the request
  task automatic start(input logic m, input job_t j);
    cmp_t c;
    issq.push_back(j);
    c.err  = !(j.delay >= 1 && j.delay <= TO);
    c.data = c.err ? 32'h0 : j.rdata;
    if (m) begin
      exp1.push_back(c);
      m1_valid_i = 1; m1_read_i = j.rd; m1_write_i = j.wr; m1_addr_i = j.addr; m1_data_i = j.data;
    end else begin
      exp0.push_back(c);
      m0_valid_i = 1; m0_read_i = j.rd; m0_write_i = j.wr; m0_addr_i = j.addr; m0_data_i = j.data;
    end
  endtask
  task automatic tick;
    @(posedge mem_clk);
    #1;
    if (m0_valid_o) begin
      if (jobs0.size() != 0) start(1'b0, jobs0.pop_front()); else m0_valid_i = 0;
    end
    if (m1_valid_o) begin
      if (jobs1.size() != 0) start(1'b1, jobs1.pop_front()); else m1_valid_i = 0;
    end
  endtask
  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((issq.size() + exp0.size() + exp1.size() != 0 || m0_valid_i || m1_valid_i) && n < max) begin
      tick();
      n++;
    end
    chk(tag, 64'(issq.size() + exp0.size() + exp1.size()), 64'd0);
  endtask
  task automatic do_reset;
    cpu_reset = 1;
    tick();
    tick();
    cpu_reset = 0;
  endtask
  always @(negedge mem_clk) if (!cpu_reset) begin
    if (mem_valid_o) begin
      if (issq.size() == 0) chk("issue_unexpected", 64'(issq.size()), 64'd1);
      else begin
        je = issq.pop_front();
        chk("issue_addr", 64'(mem_addr_o), 64'(je.addr));
        chk("issue_data", 64'(mem_data_o), 64'(je.data));
        chk("issue_rw", 64'({mem_read_o, mem_write_o}), 64'({je.rd, je.wr}));
        nxt_delay <= je.delay;
        nxt_data  <= je.rdata;
      end
    end
    if (m0_valid_o || m1_valid_o) chk("both_valid", 64'(m0_valid_o & m1_valid_o), 64'd0);
    if (m0_valid_o) begin
      comp0 <= comp0 + 1;
      if (exp0.size() == 0) chk("m0_unexpected", 64'(exp0.size()), 64'd1);
      else begin
        ce = exp0.pop_front();
        chk("m0_data", 64'(m0_data_o), 64'(ce.data));
        chk("m0_err", 64'(m0_err_o), 64'(ce.err));
      end
    end
    if (m1_valid_o) begin
      comp1 <= comp1 + 1;
      if (exp1.size() == 0) chk("m1_unexpected", 64'(exp1.size()), 64'd1);
      else begin
        ce = exp1.pop_front();
        chk("m1_data", 64'(m1_data_o), 64'(ce.data));
        chk("m1_err", 64'(m1_err_o), 64'(ce.err));
      end
    end
  end
  // Peripheral: responds delay cycles after the issue cycle; delay 0 never responds
  always @(posedge mem_clk) begin
    if (cpu_reset) begin
      pend <= 0;
      mem_valid_i <= 1'b0;
      mem_data_i <= 32'h0;
    end else if (mem_valid_o) begin
      mem_valid_i <= (nxt_delay == 1);
      mem_data_i  <= (nxt_delay == 1) ? nxt_data : $urandom;
      pend        <= (nxt_delay > 1) ? nxt_delay - 1 : 0;
    end else begin
      mem_valid_i <= (pend == 1);
      mem_data_i  <= (pend == 1) ? nxt_data : $urandom;
      pend        <= (pend > 0) ? pend - 1 : 0;
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout observed running expected finished");
    $fatal(1);
  end
  initial begin
    int n, t0, t1, c0, c1;
    job_t j;
    tick();
    tick();
    chk("rst_outs", 64'(|{mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_o,
        m0_valid_o, m1_valid_o, m0_data_o, m1_data_o, m0_err_o, m1_err_o}), 64'd0);
    cpu_reset = 0;
    start(1'b0, '{1'b1, 1'b0, 32'h81000004, 32'h0, 1, 32'h2A});
    tick();
    chk("t30_issue_n1", 64'(mem_valid_o), 64'd1);
    tick();
    chk("t30_issue_pulse", 64'(mem_valid_o), 64'd0);
    chk("t30_resp_n2", 64'(mem_valid_i), 64'd1);
    tick();
    chk("t30_valid_n3", 64'(m0_valid_o), 64'd1);
    chk("t30_data_n3", 64'(m0_data_o), 64'h2A);
    chk("t30_err_n3", 64'(m0_err_o), 64'd0);
    drain("t30_drain", 50);
    do_reset();
    c0 = comp0; c1 = comp1; t0 = -1; t1 = -1;
    start(1'b0, '{1'b0, 1'b1, 32'h81000000, 32'h1, 1, 32'h0});
    start(1'b1, '{1'b0, 1'b1, 32'h81000008, 32'h5, 1, 32'h0});
    for (int i = 0; i < 20; i++) begin
      tick();
      if (m0_valid_o && t0 < 0) t0 = i;
      if (mem_valid_o && mem_addr_o == 32'h81000008 && t1 < 0) t1 = i;
    end
    chk("t31_m1_after_m0", 64'(t1 - t0), 64'd1);
    chk("t31_m0_count", 64'(comp0 - c0), 64'd1);
    chk("t31_m1_count", 64'(comp1 - c1), 64'd1);
    drain("t31_drain", 50);
    jobs0.push_back('{1'b1, 1'b0, 32'h81000104, 32'h0, 3, 32'hA1});
    jobs0.push_back('{1'b0, 1'b0, 32'h81000108, 32'h3, 1, 32'hA2});
    jobs1.push_back('{1'b1, 1'b1, 32'h82000004, 32'h4, 1, 32'hB1});
    jobs1.push_back('{1'b1, 1'b0, 32'h82000008, 32'h0, 4, 32'hB2});
    start(1'b0, '{1'b1, 1'b0, 32'h81000100, 32'h0, 1, 32'hA0});
    start(1'b1, '{1'b0, 1'b1, 32'h82000000, 32'h9, 2, 32'hB0});
    drain("t32_drain", 200);
    start(1'b1, '{1'b1, 1'b0, 32'h90000000, 32'h0, 0, 32'h0});
    n = 0;
    while (!mem_valid_o && n < 10) begin tick(); n++; end
    n = 0;
    do begin tick(); n++; end while (!m1_valid_o && n < 40);
    chk("t33_latency", 64'(n), 64'd17);
    chk("t33_err", 64'(m1_err_o), 64'd1);
    chk("t33_data", 64'(m1_data_o), 64'd0);
    chk("t33_m0_data_kept", 64'(m0_data_o), 64'hA2);
    tick();
    tick();
    chk("t33_idle", 64'(mem_valid_o), 64'd0);
    drain("t33_drain", 20);
    start(1'b0, '{1'b1, 1'b0, 32'h81000010, 32'h0, TO, 32'h55});
    n = 0;
    while (!mem_valid_o && n < 10) begin tick(); n++; end
    n = 0;
    do begin tick(); n++; end while (!m0_valid_o && n < 40);
    chk("t34_latency", 64'(n), 64'd17);
    chk("t34_err", 64'(m0_err_o), 64'd0);
    chk("t34_data", 64'(m0_data_o), 64'h55);
    drain("t34_drain", 20);
    j = '{1'b1, 1'b0, 32'h81000020, 32'h0, 0, 32'h0};
    start(1'b0, j);
    n = 0;
    while (!mem_valid_o && n < 10) begin tick(); n++; end
    tick();
    tick();
    tick();
    cpu_reset = 1;
    exp0.delete();
    tick();
    chk("t35_rst_outs", 64'(|{mem_valid_o, mem_read_o, mem_write_o, mem_addr_o, mem_data_o,
        m0_valid_o, m1_valid_o, m0_data_o, m1_data_o, m0_err_o, m1_err_o}), 64'd0);
    tick();
    chk("t35_no_m0_valid", 64'(m0_valid_o), 64'd0);
    j.delay = 1;
    j.rdata = 32'h77;
    issq.push_back(j);
    exp0.push_back('{32'h77, 1'b0});
    cpu_reset = 0;
    tick();
    chk("t35_reissue", 64'(mem_valid_o), 64'd1);
    drain("t35_drain", 50);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
